udt_user_traffic: RTL
=====================

# udt_user_traffic

User-side traffic generator and checker for the UDT core's application streams. It drives `tx_axis_*` into the UDT core with a deterministic frame pattern and consumes `rx_axis_*` from the far-end core, checking every beat against the same pattern. It raises `finish` and `err` for the system testbench. One instance sits on each side of a client/server loopback, on the user clock domain.

## Interface
Parameters:
- `FRAME_BEATS`, 16: 64-bit beats per frame; range 1..65535.
- `NUM_FRAMES`, 64: frames per run; range 1..65535.
- `RX_STALL`, 0: when 1, `rx_axis_tready` is throttled by an LFSR; when 0, it is held high.

Ports (`core_clk` is the only clock; `core_rst_n` is asynchronous and active-low):
- `core_clk` in 1: user/core clock.
- `core_rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle pulse that begins a run.
- `tx_axis_tvalid` out 1: transmit beat valid.
- `tx_axis_tready` in 1: UDT core accepts the transmit beat.
- `tx_axis_tlast` out 1: last beat of the frame.
- `tx_axis_tkeep` out 8: byte enables.
- `tx_axis_tdata` out 64: pattern word.
- `rx_axis_tvalid` in 1: receive beat valid.
- `rx_axis_tready` out 1: checker ready.
- `rx_axis_tlast` in 1: receive last beat.
- `rx_axis_tkeep` in 8: receive byte enables.
- `rx_axis_tdata` in 64: received word.
- `tx_done` out 1: all beats have been sent.
- `rx_done` out 1: all expected beats have been received.
- `finish` out 1: `tx_done & rx_done`.
- `err` out 1: sticky error flag.
- `err_count` out 16: count of erroneous beats, saturating.
- `rx_beat_count` out 32: number of accepted receive beats.

## Operation
- TOTAL = `FRAME_BEATS*NUM_FRAMES`, held in a 32-bit constant.
- The generator FSM has three states: IDLE, SEND, DONE.
  - IDLE or DONE plus `start` → SEND. Entering SEND clears the tx and rx counters, `err`, `err_count`, `tx_done` and `rx_done`.
  - `start` is ignored while in SEND.
  - SEND → DONE on the handshake of beat TOTAL-1. On that transition `tx_done` is set to 1.
- Transmit beat n, for n = 0..TOTAL-1:
  - `tx_axis_tdata` = {16'hA5C3, frame index[15:0], n[31:0]}.
  - `tx_axis_tkeep` = 8'hFF.
  - `tx_axis_tlast` = 1 when (n mod FRAME_BEATS) == FRAME_BEATS-1.
- AXI-Stream rules on the transmit side:
  - Once `tx_axis_tvalid` is asserted, it and the data/keep/last outputs stay stable until `tx_axis_tready` is sampled high.
  - `tx_axis_tvalid` never depends combinationally on `tx_axis_tready`.
  - All tx outputs are registered.
- The checker runs independently of the generator FSM.
  - It is armed from `start` until the beat count reaches TOTAL.
  - An rx beat is accepted when `rx_axis_tvalid & rx_axis_tready`.
  - The expected word for beat m is generated with the same rule as transmit beat n (m in place of n).
- A beat is erroneous if any of these holds: data ≠ expected, `rx_axis_tkeep` ≠ 8'hFF, `rx_axis_tlast` ≠ expected last, or the beat arrives after `rx_done` is set.
  - One erroneous beat adds 1 to `err_count`, regardless of how many fields mismatch.
  - `err` is set on the same edge as the increment.
  - `err_count` saturates at 16'hFFFF.
- `rx_beat_count` increments on every accepted beat, including excess beats, and wraps at 2^32. `rx_done` is set when the count reaches TOTAL.
- `rx_axis_tready`:
  - With `RX_STALL`=0 it is 1 whenever the block is out of reset.
  - With `RX_STALL`=1 it equals bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) that advances every cycle.
- Asserting `core_rst_n` low mid-run aborts immediately. All state returns to reset values, and a new `start` is required.

## Timing
- Reset values:
  - `tx_axis_tvalid`=0, `tx_axis_tlast`=0, `tx_axis_tkeep`=0, `tx_axis_tdata`=0.
  - `tx_done`=0, `rx_done`=0, `finish`=0, `err`=0, `err_count`=0, `rx_beat_count`=0.
  - `rx_axis_tready`=0 while reset is asserted. After release it is 1 (`RX_STALL`=0) or follows the LFSR.
  - FSM in IDLE; LFSR at its seed.
- `start` sampled at edge k: `tx_axis_tvalid`=1 carrying beat 0 after edge k+1.
- With `tx_axis_tready` held high, one beat transfers per cycle with no bubbles. After the handshake of the last beat, `tx_axis_tvalid` drops on the next edge.
- Checker latency is one edge. `err`, `err_count`, `rx_beat_count` and `rx_done` update at the edge following the accepting edge; `finish` updates in the same cycle as the later of `tx_done`/`rx_done`.
- If `start` coincides with an rx beat while in DONE, the clear takes priority and that beat is discarded.

## Test plan
- FRAME_BEATS=4, NUM_FRAMES=2, tx output looped to rx, ready held high → 8 beats. Beat 3 has tdata=64'hA5C3_0000_0000_0003 and tlast=1; beat 7 has frame field 1. `finish`=1 at cycle 10 after `start`, `err`=0.
- Same loop with `tx_axis_tready` toggling 1010… → tvalid/tdata are stable during every stall, all 8 beats arrive in order, and `err_count`=0.
- Corrupt bit 0 of rx beat 5 and force tkeep=8'h0F on beat 6 → `err_count`=2, `err`=1, `rx_done`=1 after 8 beats.
- Inject 3 extra beats after TOTAL → `rx_beat_count`=11 and `err_count`=3.
- RX_STALL=1 with a FIFO-buffered loop, FRAME_BEATS=16, NUM_FRAMES=64 → 1024 beats with `err`=0. `rx_axis_tready` matches the LFSR reference model each cycle.
- Assert `core_rst_n` low mid-run at beat 10 → all outputs go to reset values. `start` afterwards → beat 0 with n=0 again, and the full run passes.

Source files
------------

// File: rtl/udt_user_traffic_if.sv
// AXI-Stream style beat bundle used on both sides of the user traffic block.
// master: drives valid/last/keep/data, receives ready.
// slave : receives valid/last/keep/data, drives ready.
interface udt_user_traffic_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;

    modport master (output tvalid, output tlast, output tkeep, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tkeep, input tdata, output tready);
endinterface

// File: rtl/udt_user_traffic.sv
// User-side traffic generator and checker for the UDT application streams.
// The generator sends FRAME_BEATS*NUM_FRAMES pattern beats on tx_axis after a
// start pulse; the checker compares every beat received on rx_axis against the
// same pattern and counts erroneous beats.
//
// Ports:
//   core_clk, core_rst_n  clock and asynchronous active-low reset
//   start                 single-cycle pulse that begins a run
//   tx_axis (master)      generated pattern stream
//   rx_axis (slave)       far-end stream to be checked
//   tx_done, rx_done      all beats sent / all expected beats received
//   finish                tx_done & rx_done
//   err, err_count        sticky error flag and saturating erroneous-beat count
//   rx_beat_count         accepted receive beats, wraps at 2^32
//
// Generator states:
//   state   | meaning
//   IDLE    | out of reset, waiting for start
//   SEND    | presenting pattern beats, start ignored
//   DONE    | last beat handed off, start begins a new run
module udt_user_traffic #(
    parameter int unsigned FRAME_BEATS = 16,
    parameter int unsigned NUM_FRAMES  = 64,
    parameter bit          RX_STALL    = 1'b0
) (
    input  logic               core_clk,
    input  logic               core_rst_n,
    input  logic               start,
    udt_user_traffic_if.master tx_axis,
    udt_user_traffic_if.slave  rx_axis,
    output logic               tx_done,
    output logic               rx_done,
    output logic               finish,
    output logic               err,
    output logic [15:0]        err_count,
    output logic [31:0]        rx_beat_count
);

    localparam logic [31:0] TOTAL       = 32'(FRAME_BEATS * NUM_FRAMES);
    localparam logic [15:0] LAST_POS    = 16'(FRAME_BEATS - 1);
    localparam logic [15:0] PATTERN_TAG = 16'hA5C3;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic        start_go;

    // tx_n counts beats already loaded into the output register, so the
    // beat on the bus is tx_n-1 and tx_n == TOTAL means nothing left to load.
    logic [31:0] tx_n;
    logic [15:0] tx_frame;
    logic [15:0] tx_pos;
    logic        tx_load;
    logic        tx_last_hs;

    logic        tx_valid_q;
    logic        tx_last_q;
    logic [7:0]  tx_keep_q;
    logic [63:0] tx_data_q;

    logic        rx_ready;
    logic        rx_accept;
    logic        rx_armed;
    logic [15:0] rx_frame;
    logic [15:0] rx_pos;

    logic        s1_valid;
    logic        s1_last;
    logic [7:0]  s1_keep;
    logic [63:0] s1_data;

    logic [63:0] exp_data;
    logic        exp_last;
    logic        beat_bad;

    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign start_go   = start && (state != ST_SEND);
    assign tx_load    = (state == ST_SEND) && (tx_n != TOTAL) && (!tx_valid_q || tx_axis.tready);
    assign tx_last_hs = (state == ST_SEND) && (tx_n == TOTAL) && tx_valid_q && tx_axis.tready;

    assign tx_axis.tvalid = tx_valid_q;
    assign tx_axis.tlast  = tx_last_q;
    assign tx_axis.tkeep  = tx_keep_q;
    assign tx_axis.tdata  = tx_data_q;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state      <= ST_IDLE;
            tx_n       <= '0;
            tx_frame   <= '0;
            tx_pos     <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_keep_q  <= '0;
            tx_data_q  <= '0;
            tx_done    <= 1'b0;
        end else if (start_go) begin
            state      <= ST_SEND;
            tx_n       <= '0;
            tx_frame   <= '0;
            tx_pos     <= '0;
            tx_valid_q <= 1'b0;
            tx_done    <= 1'b0;
        end else if (tx_last_hs) begin
            state      <= ST_DONE;
            tx_valid_q <= 1'b0;
            tx_done    <= 1'b1;
        end else if (tx_load) begin
            tx_valid_q <= 1'b1;
            tx_last_q  <= (tx_pos == LAST_POS);
            tx_keep_q  <= 8'hFF;
            tx_data_q  <= {PATTERN_TAG, tx_frame, tx_n};
            tx_n       <= tx_n + 32'd1;
            if (tx_pos == LAST_POS) begin
                tx_pos   <= '0;
                tx_frame <= tx_frame + 16'd1;
            end else begin
                tx_pos   <= tx_pos + 16'd1;
            end
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 of the right-shifting form).
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    // Ready is gated by reset directly so it reads 0 for the whole reset
    // window and takes the seed value the moment reset releases.
    assign rx_ready       = core_rst_n && (RX_STALL ? lfsr[0] : 1'b1);
    assign rx_axis.tready = rx_ready;
    assign rx_accept      = rx_axis.tvalid && rx_ready;

    always_comb begin
        exp_data = {PATTERN_TAG, rx_frame, rx_beat_count};
        exp_last = (rx_pos == LAST_POS);
        beat_bad = rx_done || (s1_data != exp_data) || (s1_keep != 8'hFF) || (s1_last != exp_last);
    end

    // Beats are captured on the accepting edge and scored on the next one.
    // Beats seen before the first start are dropped; once rx_done is set every
    // further beat is still counted, and scored as an error.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_keep       <= '0;
            s1_data       <= '0;
            rx_armed      <= 1'b0;
            rx_frame      <= '0;
            rx_pos        <= '0;
            rx_beat_count <= '0;
            rx_done       <= 1'b0;
            err           <= 1'b0;
            err_count     <= '0;
        end else if (start_go) begin
            s1_valid      <= 1'b0;
            rx_armed      <= 1'b1;
            rx_frame      <= '0;
            rx_pos        <= '0;
            rx_beat_count <= '0;
            rx_done       <= 1'b0;
            err           <= 1'b0;
            err_count     <= '0;
        end else begin
            s1_valid <= rx_accept && (rx_armed || rx_done);
            s1_last  <= rx_axis.tlast;
            s1_keep  <= rx_axis.tkeep;
            s1_data  <= rx_axis.tdata;
            if (s1_valid) begin
                rx_beat_count <= rx_beat_count + 32'd1;
                if (rx_pos == LAST_POS) begin
                    rx_pos   <= '0;
                    rx_frame <= rx_frame + 16'd1;
                end else begin
                    rx_pos   <= rx_pos + 16'd1;
                end
                if (rx_beat_count + 32'd1 == TOTAL) begin
                    rx_done  <= 1'b1;
                    rx_armed <= 1'b0;
                end
                if (beat_bad) begin
                    err <= 1'b1;
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                end
            end
        end
    end

    assign finish = tx_done && rx_done;

endmodule
